// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Word-addressed data-memory responder for the CPU load/store port. Takes one
//   request at a time over valid/ready, waits LATENCY cycles, then presents a
//   response (load data or store acknowledgement plus error flag) that is held
//   until the requester consumes it.
//
// Parameters
//   DEPTH      number of 32-bit words in the array (power of 2, >= 2)
//   LATENCY    wait cycles between accept and response (0..15)
//   BASE_ADDR  byte address mapped to word 0 (4-byte aligned)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request (registered)
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data
//   resp_valid  response present
//   resp_ready  requester consumes the response
//   resp_rdata  load data (0 for stores and errored requests)
//   resp_err    request was misaligned or out of range
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e             state_q, state_d;
   logic               ready_q, ready_d;
   logic [3:0]         cnt_q,   cnt_d;
   logic               we_q,    we_d;
   logic               err_q,   err_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               rerr_q,  rerr_d;

   logic [31:0]        mem [DEPTH];

   logic [31:0]        off;
   logic               req_err;
   logic               accept;
   logic               finish;
   logic               x_we;
   logic               x_err;
   logic [IDX_W-1:0]   x_idx;
   logic [31:0]        x_wdata;
   logic               mem_we;

   // BASE_ADDR is word aligned, so off[1:0] equals req_addr[1:0].
   assign off     = req_addr - BASE_ADDR;
   assign req_err = (off[1:0] != 2'b00) || ({2'b00, off[31:2]} >= DEPTH);
   assign accept  = (state_q == S_IDLE) && ready_q && req_valid;

   // With LATENCY=0 the access completes on the accept edge itself, so the
   // live request fields are used while still in IDLE.
   assign x_we    = (state_q == S_IDLE) ? req_we             : we_q;
   assign x_err   = (state_q == S_IDLE) ? req_err            : err_q;
   assign x_idx   = (state_q == S_IDLE) ? off[IDX_W+1:2]     : idx_q;
   assign x_wdata = (state_q == S_IDLE) ? req_wdata          : wdata_q;

   always_comb begin
      state_d = state_q;
      // req_ready follows IDLE with one cycle of lag after returning there.
      ready_d = (state_q == S_IDLE) && !accept;
      cnt_d   = cnt_q;
      we_d    = we_q;
      err_d   = err_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rerr_d  = rerr_q;
      finish  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d    = req_we;
               err_d   = req_err;
               idx_d   = off[IDX_W+1:2];
               wdata_d = req_wdata;
               if (LATENCY == 0) begin
                  finish = 1'b1;
               end else begin
                  cnt_d   = 4'(LATENCY);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               finish = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
               rdata_d = '0;
               rerr_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (finish) begin
         state_d = S_RESP;
         cnt_d   = '0;
         rerr_d  = x_err;
         rdata_d = (x_we || x_err) ? '0 : mem[x_idx];
      end
   end

   assign mem_we = finish && x_we && !x_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
      end
   end

   // Array contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[x_idx] <= x_wdata;
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Four responders (LATENCY 2, 0, 1, 15) on a shared clock and reset, each
//   with its own request/response signals. Expected responses come from a
//   per-instance memory model and are queued when a request is driven.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int NDUT = 4;
   localparam int LATS [NDUT] = '{2, 0, 1, 15};

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        rv     [NDUT];
   logic        rdy    [NDUT];
   logic        rwe    [NDUT];
   logic [31:0] raddr  [NDUT];
   logic [31:0] rwdata [NDUT];
   logic        vld    [NDUT];
   logic        rr     [NDUT];
   logic [31:0] rdata  [NDUT];
   logic        err    [NDUT];

   logic [31:0] model  [NDUT][256];
   int          last_acc [NDUT];
   exp_t        sbq [$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      dmem_responder #(
         .DEPTH     (256),
         .LATENCY   ((g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 1 : 15),
         .BASE_ADDR (32'h0000_0000)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (rv[g]),
         .req_ready  (rdy[g]),
         .req_we     (rwe[g]),
         .req_addr   (raddr[g]),
         .req_wdata  (rwdata[g]),
         .resp_valid (vld[g]),
         .resp_ready (rr[g]),
         .resp_rdata (rdata[g]),
         .resp_err   (err[g])
      );
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input int k, input string name);
      check({name, "_rdy"},   32'(rdy[k]),  32'd0);
      check({name, "_vld"},   32'(vld[k]),  32'd0);
      check({name, "_rdata"}, rdata[k],     32'd0);
      check({name, "_err"},   32'(err[k]),  32'd0);
   endtask

   // One full transaction on instance k; hold = cycles of resp_ready=0 after
   // resp_valid rises; b2b checks spacing from the previous accept.
   task automatic xfer(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold, input bit b2b);
      exp_t e;
      int   n;
      bit   bad;
      bad     = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
      e.err   = bad;
      e.rdata = (we || bad) ? 32'd0 : model[k][addr[9:2]];
      if (we && !bad) model[k][addr[9:2]] = wd;
      sbq.push_back(e);

      n = 0;
      while (rdy[k] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_req", 32'(rdy[k]), 32'd1);

      rv[k]     = 1'b1;
      rwe[k]    = we;
      raddr[k]  = addr;
      rwdata[k] = wd;
      rr[k]     = (hold == 0);
      @(negedge clk);
      if (b2b) check("b2b_period", 32'(cyc - last_acc[k]), 32'(LATS[k] + 3));
      last_acc[k] = cyc;
      check("ready_drop", 32'(rdy[k]), 32'd0);

      n = 1;
      while (vld[k] !== 1'b1 && n < 40) begin
         rv[k]     = 1'($urandom);
         rwe[k]    = 1'($urandom);
         raddr[k]  = $urandom;
         rwdata[k] = $urandom;
         @(negedge clk);
         n++;
      end
      rv[k] = 1'b0;
      check("latency_edges", 32'(n), 32'(LATS[k] + 1));

      e = sbq.pop_front();
      check("resp_rdata", rdata[k], e.rdata);
      check("resp_err", 32'(err[k]), 32'(e.err));

      for (int i = 0; i < hold; i++) begin
         raddr[k] = $urandom;
         @(negedge clk);
         check("hold_vld", 32'(vld[k]), 32'd1);
         check("hold_rdata", rdata[k], e.rdata);
         check("hold_rdy", 32'(rdy[k]), 32'd0);
      end
      rr[k] = 1'b1;
      @(negedge clk);
      rr[k] = 1'b0;
      check("post_hs_vld", 32'(vld[k]), 32'd0);
      check("post_hs_rdata", rdata[k], 32'd0);
      check("post_hs_err", 32'(err[k]), 32'd0);
      check("post_hs_rdy_lag", 32'(rdy[k]), 32'd0);
      @(negedge clk);
      check("idle_rdy", 32'(rdy[k]), 32'd1);
   endtask

   initial begin
      int vld_seen;
      for (int k = 0; k < NDUT; k++) begin
         rv[k] = 1'b0; rwe[k] = 1'b0; raddr[k] = '0; rwdata[k] = '0; rr[k] = 1'b0;
         last_acc[k] = 0;
      end

      // Reset behaviour
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NDUT; k++) check_idle_outputs(k, "reset");
      rst = 1'b1;
      #1;
      for (int k = 0; k < NDUT; k++) check("rdy_before_edge", 32'(rdy[k]), 32'd0);
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) check("rdy_after_edge", 32'(rdy[k]), 32'd1);

      // Store then load, LATENCY=2
      xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
      xfer(0, 1'b0, 32'h10, 32'h0, 0, 1'b1);

      // Backpressure on a load
      xfer(0, 1'b0, 32'h10, 32'h0, 5, 1'b0);

      // Errors and boundary words
      xfer(0, 1'b1, 32'h0,   32'hCAFE_0000, 0, 1'b0);
      xfer(0, 1'b0, 32'h13,  32'h0, 0, 1'b0);
      xfer(0, 1'b1, 32'h400, 32'h1, 0, 1'b0);
      xfer(0, 1'b1, 32'h22,  32'h7, 0, 1'b0);
      xfer(0, 1'b0, 32'h0,   32'h0, 0, 1'b0);
      xfer(0, 1'b1, 32'h3FC, 32'h1234_5678, 0, 1'b0);
      xfer(0, 1'b0, 32'h3FC, 32'h0, 0, 1'b1);

      // Latency sweep with back-to-back traffic
      for (int k = 1; k < NDUT; k++) begin
         xfer(k, 1'b1, 32'h40,  32'hA5A5_0000 + 32'(k), 0, 1'b0);
         xfer(k, 1'b0, 32'h40,  32'h0, 0, 1'b1);
         xfer(k, 1'b1, 32'h3FC, 32'h0BAD_F00D, 0, 1'b1);
         xfer(k, 1'b0, 32'h3FC, 32'h0, 0, 1'b1);
         xfer(k, 1'b0, 32'h404, 32'h0, 0, 1'b1);
         xfer(k, 1'b0, 32'h40,  32'h0, 2, 1'b0);
      end

      // Reset while a store sits in WAIT
      xfer(0, 1'b1, 32'h20, 32'h1111_1111, 0, 1'b0);
      rv[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 32'h20; rwdata[0] = 32'h55; rr[0] = 1'b1;
      @(negedge clk);
      rv[0] = 1'b0;
      check("abort_in_wait_rdy", 32'(rdy[0]), 32'd0);
      rst = 1'b0;
      #1;
      check_idle_outputs(0, "abort_reset");
      @(negedge clk);
      rst = 1'b1;
      vld_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (vld[0] === 1'b1) vld_seen++;
      end
      check("abort_no_resp", 32'(vld_seen), 32'd0);
      rr[0] = 1'b0;
      xfer(0, 1'b0, 32'h20, 32'h0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
